// File: rtl/pid_mc_core_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pid_mc_core_pkg : FSM encoding and width helpers for the multi-channel PID
// Revision 1.0
// ----------------------------------------------------------------------------
package pid_mc_core_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ERR  = 3'd1,
        ST_MP   = 3'd2,
        ST_MI   = 3'd3,
        ST_MD   = 3'd4,
        ST_SUM  = 3'd5
    } pid_state_e;

    // Channel index width, never narrower than one bit.
    function automatic int chw(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

    // Signed multiplier operand width: wide enough for d (W+2) and the integrator.
    function automatic int opw(input int w, input int iw);
        return (iw > w + 2) ? iw : w + 2;
    endfunction

    // Accumulator width: one product plus headroom for summing three of them.
    function automatic int accw(input int w, input int kw, input int iw);
        return kw + opw(w, iw) + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pid_mc_core_sat.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pid_mc_core_sat : saturating narrow of a signed value to signed or unsigned
// Revision 1.0
// ----------------------------------------------------------------------------
module pid_mc_core_sat #(
    parameter int IN_W       = 13,
    parameter int OUT_W      = 12,
    parameter bit SIGNED_OUT = 1'b1
) (
    input  logic signed [IN_W-1:0]  in_i,
    output logic        [OUT_W-1:0] out_o
);

    localparam logic signed [IN_W-1:0] C_MAX = SIGNED_OUT
        ? {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}}
        : {{(IN_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};
    localparam logic signed [IN_W-1:0] C_MIN = SIGNED_OUT
        ? {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}}
        : {IN_W{1'b0}};

    always_comb begin
        out_o = in_i[OUT_W-1:0];
        if (in_i > C_MAX) begin
            out_o = C_MAX[OUT_W-1:0];
        end else if (in_i < C_MIN) begin
            out_o = C_MIN[OUT_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/pid_mc_core.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pid_mc_core : time-multiplexed PID engine, CH loops sharing one multiplier
// Revision 1.0
// ----------------------------------------------------------------------------
module pid_mc_core
    import pid_mc_core_pkg::*;
#(
    parameter int W    = 8,
    parameter int KW   = 8,
    parameter int FRAC = 4,
    parameter int IW   = 12,
    parameter int CH   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic [CH*W-1:0]       sp,
    input  logic [CH*KW-1:0]      kp,
    input  logic [CH*KW-1:0]      ki,
    input  logic [CH*KW-1:0]      kd,
    input  logic                  pv_valid,
    input  logic [chw(CH)-1:0]    pv_ch,
    input  logic [W-1:0]          pv,
    output logic                  pv_ready,
    output logic                  out_valid,
    output logic [chw(CH)-1:0]    out_ch,
    output logic [W-1:0]          out,
    output logic                  sat
);

    localparam int             CW     = chw(CH);
    localparam int             OPW    = opw(W, IW);
    localparam int             AW     = accw(W, KW, IW);
    localparam int             PW     = OPW + KW + 1;
    localparam logic [CW:0]    C_CH_N = (CW+1)'(CH);

    pid_state_e               state_q, state_d;
    logic [CW-1:0]            ch_q;
    logic [W-1:0]             pv_q, sp_q;
    logic [KW-1:0]            kp_q, ki_q, kd_q;
    logic signed [W:0]        e_q;
    logic signed [W+1:0]      d_q;
    logic signed [IW-1:0]     ic_q;
    logic signed [AW-1:0]     acc_q;
    logic signed [IW-1:0]     integ_q [CH];
    logic signed [W:0]        eprev_q [CH];
    logic [W-1:0]             out_q;
    logic [CW-1:0]            out_ch_q;
    logic                     sat_q, out_valid_q;

    logic                     w_ch_ok, w_accept;
    logic signed [W:0]        w_e;
    logic signed [W+1:0]      w_d;
    logic signed [IW:0]       w_isum;
    logic signed [IW-1:0]     w_ic;
    logic signed [OPW-1:0]    w_opa;
    logic [KW-1:0]            w_gain;
    logic signed [PW-1:0]     w_prod;
    logic signed [AW-1:0]     w_r;
    logic [W-1:0]             w_clamp;
    logic                     w_lo, w_hi, w_e_pos, w_e_neg, w_hold;

    assign pv_ready  = (state_q == ST_IDLE) && !reset && !clr;
    assign w_ch_ok   = ({1'b0, pv_ch} < C_CH_N);
    assign w_accept  = pv_valid && pv_ready && w_ch_ok;

    // Error terms are formed from the latched operands while in ERR.
    assign w_e    = $signed({1'b0, sp_q}) - $signed({1'b0, pv_q});
    assign w_d    = {w_e[W], w_e} - {eprev_q[ch_q][W], eprev_q[ch_q]};
    assign w_isum = {integ_q[ch_q][IW-1], integ_q[ch_q]} + {{(IW-W){w_e[W]}}, w_e};

    pid_mc_core_sat #(.IN_W(IW+1), .OUT_W(IW), .SIGNED_OUT(1'b1)) u_isat (
        .in_i  (w_isum),
        .out_o (w_ic)
    );

    always_comb begin
        w_opa  = OPW'(e_q);
        w_gain = kp_q;
        case (state_q)
            ST_MI: begin
                w_opa  = OPW'(ic_q);
                w_gain = ki_q;
            end
            ST_MD: begin
                w_opa  = OPW'(d_q);
                w_gain = kd_q;
            end
            default: ;
        endcase
    end

    assign w_prod = w_opa * $signed({1'b0, w_gain});

    assign w_r     = acc_q >>> FRAC;
    assign w_lo    = w_r[AW-1];
    assign w_hi    = !w_lo && (|w_r[AW-2:W]);
    assign w_e_neg = e_q[W];
    assign w_e_pos = !e_q[W] && (|e_q);
    // Freeze the integrator only when the error would push further into saturation.
    assign w_hold  = (w_hi && w_e_pos) || (w_lo && w_e_neg);

    pid_mc_core_sat #(.IN_W(AW), .OUT_W(W), .SIGNED_OUT(1'b0)) u_osat (
        .in_i  (w_r),
        .out_o (w_clamp)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (w_accept) state_d = ST_ERR;
                ST_ERR:  state_d = ST_MP;
                ST_MP:   state_d = ST_MI;
                ST_MI:   state_d = ST_MD;
                ST_MD:   state_d = ST_SUM;
                ST_SUM:  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ch_q        <= '0;
            pv_q        <= '0;
            sp_q        <= '0;
            kp_q        <= '0;
            ki_q        <= '0;
            kd_q        <= '0;
            e_q         <= '0;
            d_q         <= '0;
            ic_q        <= '0;
            acc_q       <= '0;
            out_q       <= '0;
            out_ch_q    <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            for (int c = 0; c < CH; c++) begin
                integ_q[c] <= '0;
                eprev_q[c] <= '0;
            end
        end else begin
            out_valid_q <= 1'b0;
            if (clr) begin
                for (int c = 0; c < CH; c++) begin
                    integ_q[c] <= '0;
                    eprev_q[c] <= '0;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (w_accept) begin
                            ch_q <= pv_ch;
                            pv_q <= pv;
                            sp_q <= sp[int'(pv_ch)*W +: W];
                            kp_q <= kp[int'(pv_ch)*KW +: KW];
                            ki_q <= ki[int'(pv_ch)*KW +: KW];
                            kd_q <= kd[int'(pv_ch)*KW +: KW];
                        end
                    end
                    ST_ERR: begin
                        e_q   <= w_e;
                        d_q   <= w_d;
                        ic_q  <= w_ic;
                        acc_q <= '0;
                    end
                    ST_MP, ST_MI, ST_MD: begin
                        acc_q <= acc_q + AW'(w_prod);
                    end
                    ST_SUM: begin
                        out_q         <= w_clamp;
                        sat_q         <= w_lo || w_hi;
                        out_ch_q      <= ch_q;
                        out_valid_q   <= 1'b1;
                        eprev_q[ch_q] <= e_q;
                        if (!w_hold) begin
                            integ_q[ch_q] <= ic_q;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out       = out_q;
    assign sat       = sat_q;

endmodule
`default_nettype wire
